// File: rtl/fft16_unload_if.sv
// Frame-in / sample-out handshake bundle for fft16_unload.
// The slave side is the unloader; the master side is its environment.
interface fft16_unload_if #(
    parameter int W = 17
);
    logic [32*W-1:0] frame_in;
    logic            frame_valid;
    logic            frame_ready;
    logic [2*W-1:0]  dout;
    logic            dout_valid;
    logic            dout_ready;
    logic [3:0]      dout_index;
    logic            dout_last;

    modport master (
        output frame_in, frame_valid, dout_ready,
        input  frame_ready, dout, dout_valid, dout_index, dout_last
    );

    modport slave (
        input  frame_in, frame_valid, dout_ready,
        output frame_ready, dout, dout_valid, dout_index, dout_last
    );
endinterface

// File: rtl/fft16_unload.sv
// Ping-pong unloader: parallel 16-point FFT frame in, one sample per cycle out.
// Define FFT16_UNLOAD_NATURAL_ORDER_EN to emit bins in natural (digit-reversed slot) order.
module fft16_unload #(
    parameter int W = 17
) (
    input  logic         clk,
    input  logic         rst,
    fft16_unload_if.slave bus
);
    localparam int SW = 2 * W;
    localparam int FW = 32 * W;

    logic [FW-1:0] bank [2];
    logic [1:0]    full;
    logic          wr_ptr;
    logic          rd_ptr;
    logic [3:0]    k;
    logic [3:0]    slot;
    logic [SW-1:0] samp [16];
    logic          take;
    logic          give;

    // Handshakes look only at registered flags, so a bank freed on this
    // edge cannot be refilled until the following one.
    assign bus.frame_ready = ~full[wr_ptr];
    assign bus.dout_valid  = full[rd_ptr];
    assign take = bus.frame_valid & ~full[wr_ptr];
    assign give = full[rd_ptr] & bus.dout_ready;

`ifdef FFT16_UNLOAD_NATURAL_ORDER_EN
    assign slot = {k[1:0], k[3:2]};
`else
    assign slot = k;
`endif

    always_comb begin
        for (int s = 0; s < 16; s++) begin
            samp[s] = bank[rd_ptr][s*SW +: SW];
        end
    end

    assign bus.dout       = samp[slot];
    assign bus.dout_index = k;
    assign bus.dout_last  = full[rd_ptr] & (k == 4'd15);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bank[0] <= '0;
            bank[1] <= '0;
            full    <= '0;
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            k       <= 4'd0;
        end else begin
            if (take) begin
                bank[wr_ptr] <= bus.frame_in;
                full[wr_ptr] <= 1'b1;
                wr_ptr       <= ~wr_ptr;
            end
            if (give) begin
                k <= k + 4'd1;
                if (k == 4'd15) begin
                    full[rd_ptr] <= 1'b0;
                    rd_ptr       <= ~rd_ptr;
                end
            end
        end
    end
endmodule

// File: tb/tb_fft16_unload.sv
// Directed self-checking bench for fft16_unload.
// Expected bin order follows FFT16_UNLOAD_NATURAL_ORDER_EN when defined.
module tb_fft16_unload;
    localparam int W = 17;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   fails = 0;

    fft16_unload_if #(.W(W)) bus ();

    fft16_unload #(.W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [2*W-1:0] smp(int f, int s);
        logic [2*W-1:0] v;
        v[2*W-1:W] = W'(f * 16 + s);
        v[W-1:0]   = W'(1000 + 37 * s + f);
        return v;
    endfunction

    function automatic logic [32*W-1:0] frm(int f);
        logic [32*W-1:0] r;
        for (int s = 0; s < 16; s++) r[s*2*W +: 2*W] = smp(f, s);
        return r;
    endfunction

    function automatic int slot_of(int i);
`ifdef FFT16_UNLOAD_NATURAL_ORDER_EN
        int tbl [16] = '{0, 4, 8, 12, 1, 5, 9, 13, 2, 6, 10, 14, 3, 7, 11, 15};
        return tbl[i];
`else
        return i;
`endif
    endfunction

    // {valid, last, index, dout} for sample i of frame f
    function automatic logic [2*W+5:0] exp_out(int f, int i);
        return {1'b1, i == 15, 4'(i), smp(f, slot_of(i))};
    endfunction

    task automatic test_reset();
        bus.frame_in    = '0;
        bus.frame_valid = 1'b0;
        bus.dout_ready  = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({bus.dout_valid, bus.dout_last, bus.dout_index, bus.dout} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: got %h want 0",
                     {bus.dout_valid, bus.dout_last, bus.dout_index, bus.dout});
        end
        checks++;
        if (bus.frame_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_frame_ready: got %b want 1", bus.frame_ready);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({bus.frame_ready, bus.dout_valid, bus.dout_index} !== 6'b10_0000) begin
            fails++;
            $display("FAIL post_reset_idle: got ready=%b valid=%b idx=%0d want 1 0 0",
                     bus.frame_ready, bus.dout_valid, bus.dout_index);
        end
    endtask

    task automatic test_order();
        bus.frame_in    = frm(1);
        bus.frame_valid = 1'b1;
        bus.dout_ready  = 1'b1;
        @(posedge clk); #1;
        bus.frame_valid = 1'b0;
        checks++;
        if (bus.frame_ready !== 1'b1) begin
            fails++;
            $display("FAIL order_ready: got %b want 1", bus.frame_ready);
        end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if ({bus.dout_valid, bus.dout_last, bus.dout_index, bus.dout} !== exp_out(1, i)) begin
                fails++;
                $display("FAIL order_s%0d: got %h want %h", i,
                         {bus.dout_valid, bus.dout_last, bus.dout_index, bus.dout}, exp_out(1, i));
            end
            @(posedge clk); #1;
        end
        checks++;
        if (bus.dout_valid !== 1'b0) begin
            fails++;
            $display("FAIL order_drained: got valid=%b want 0", bus.dout_valid);
        end
    endtask

    task automatic test_back_to_back();
        bus.dout_ready  = 1'b1;
        bus.frame_in    = frm(2);
        bus.frame_valid = 1'b1;
        @(posedge clk); #1;
        bus.frame_in = frm(3);
        for (int n = 0; n < 48; n++) begin
            if (n <= 17) begin
                checks++;
                if (bus.frame_ready !== (n == 0 || n == 16)) begin
                    fails++;
                    $display("FAIL b2b_ready_c%0d: got %b want %b", n,
                             bus.frame_ready, (n == 0 || n == 16));
                end
            end
            checks++;
            if ({bus.dout_valid, bus.dout_last, bus.dout_index, bus.dout}
                !== exp_out(2 + n / 16, n % 16)) begin
                fails++;
                $display("FAIL b2b_s%0d: got %h want %h", n,
                         {bus.dout_valid, bus.dout_last, bus.dout_index, bus.dout},
                         exp_out(2 + n / 16, n % 16));
            end
            if (n == 1) bus.frame_in = frm(4);
            if (n == 17) bus.frame_valid = 1'b0;
            @(posedge clk); #1;
        end
        checks++;
        if ({bus.dout_valid, bus.frame_ready} !== 2'b01) begin
            fails++;
            $display("FAIL b2b_drained: got valid=%b ready=%b want 0 1",
                     bus.dout_valid, bus.frame_ready);
        end
    endtask

    task automatic test_stall();
        bus.dout_ready  = 1'b0;
        bus.frame_in    = frm(5);
        bus.frame_valid = 1'b1;
        @(posedge clk); #1;
        bus.frame_valid = 1'b0;
        for (int j = 0; j < 32; j++) begin
            bus.dout_ready = j[0];
            checks++;
            if ({bus.dout_valid, bus.dout_last, bus.dout_index, bus.dout} !== exp_out(5, j / 2)) begin
                fails++;
                $display("FAIL stall_c%0d: got %h want %h", j,
                         {bus.dout_valid, bus.dout_last, bus.dout_index, bus.dout}, exp_out(5, j / 2));
            end
            @(posedge clk); #1;
        end
        bus.dout_ready = 1'b1;
        checks++;
        if (bus.dout_valid !== 1'b0) begin
            fails++;
            $display("FAIL stall_drained: got valid=%b want 0", bus.dout_valid);
        end
    endtask

    task automatic test_reset_mid();
        bus.dout_ready  = 1'b1;
        bus.frame_in    = frm(6);
        bus.frame_valid = 1'b1;
        @(posedge clk); #1;
        bus.frame_in = frm(7);
        for (int n = 0; n < 8; n++) begin
            checks++;
            if ({bus.dout_valid, bus.dout_last, bus.dout_index, bus.dout} !== exp_out(6, n)) begin
                fails++;
                $display("FAIL mid_s%0d: got %h want %h", n,
                         {bus.dout_valid, bus.dout_last, bus.dout_index, bus.dout}, exp_out(6, n));
            end
            if (n == 1) bus.frame_valid = 1'b0;
            if (n < 7) begin
                @(posedge clk); #1;
            end
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({bus.dout_valid, bus.dout_last, bus.dout_index, bus.dout, bus.frame_ready}
            !== {{(2*W+6){1'b0}}, 1'b1}) begin
            fails++;
            $display("FAIL mid_reset: got v=%b l=%b i=%0d d=%h r=%b want 0 0 0 0 1",
                     bus.dout_valid, bus.dout_last, bus.dout_index, bus.dout, bus.frame_ready);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (bus.dout_valid !== 1'b0) begin
            fails++;
            $display("FAIL mid_no_leftover: got valid=%b want 0", bus.dout_valid);
        end
        bus.frame_in    = frm(8);
        bus.frame_valid = 1'b1;
        @(posedge clk); #1;
        bus.frame_valid = 1'b0;
        for (int n = 0; n < 16; n++) begin
            checks++;
            if ({bus.dout_valid, bus.dout_last, bus.dout_index, bus.dout} !== exp_out(8, n)) begin
                fails++;
                $display("FAIL mid_new_s%0d: got %h want %h", n,
                         {bus.dout_valid, bus.dout_last, bus.dout_index, bus.dout}, exp_out(8, n));
            end
            @(posedge clk); #1;
        end
        checks++;
        if (bus.dout_valid !== 1'b0) begin
            fails++;
            $display("FAIL mid_drained: got valid=%b want 0", bus.dout_valid);
        end
    endtask

    initial begin
        test_reset();
        test_order();
        test_back_to_back();
        test_stall();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/fft16_unload.md
FFT16_UNLOAD -- requirements
Module: fft16_unload

Interface
REQ-001 SHALL have parameter W, default 17, real/imag component width; sample width 2W, frame width 32W (544 at default).
REQ-002 SHALL have port clk, input, 1, sole clock, all state on rising edge.
REQ-003 SHALL have port rst, input, 1; reset is asynchronous and active-high.
REQ-004 SHALL have port frame_in, input, 32W, one 16-point FFT output frame; slot s occupies bits [2W*s+2W-1 : 2W*s].
REQ-005 SHALL have port frame_valid, input, 1, frame_in holds a valid frame.
REQ-006 SHALL have port frame_ready, output, 1, block can accept a frame this cycle.
REQ-007 SHALL have port dout, output, 2W, current output sample, slot contents passed unmodified.
REQ-008 SHALL have port dout_valid, output, 1, dout holds a valid sample.
REQ-009 SHALL have port dout_ready, input, 1, downstream accepts dout this cycle.
REQ-010 SHALL have port dout_index, output, 4, frequency-bin index k of dout.
REQ-011 SHALL have port dout_last, output, 1, high with dout_valid when dout_index = 15.

Function
REQ-012 SHALL hold two frame banks (ping-pong), each with a registered FULL/EMPTY flag, a write pointer and a read pointer.
REQ-013 SHALL drive frame_ready = 1 when the bank at the write pointer is EMPTY, derived from registered state only.
REQ-014 SHALL, on frame_valid && frame_ready, capture frame_in into the write-pointer bank, mark it FULL, toggle the write pointer.
REQ-015 SHALL ignore frame_in while frame_ready = 0; no frame is overwritten or dropped silently.
REQ-016 SHALL drive dout_valid = 1 exactly when the read-pointer bank is FULL.
REQ-017 SHALL keep a 4-bit sample counter k; dout_index = k.
REQ-018 SHALL advance k on dout_valid && dout_ready; when k = 15 transfers, wrap k to 0, mark the bank EMPTY, toggle the read pointer.
REQ-019 SHALL keep dout, dout_index, dout_last stable while dout_valid && !dout_ready.
REQ-020 SHALL produce dout from registered state only (no combinational path from frame_in, frame_valid or dout_ready to dout/dout_valid).
REQ-021 SHALL present the first sample of a frame accepted on edge t with dout_valid = 1 in the cycle after edge t when the read bank was EMPTY.
REQ-022 SHALL, when a bank is freed and a frame is offered in the same cycle, not accept into the freed bank until the next cycle (frame_ready reflects pre-edge state).
REQ-023 SHALL sustain one sample per cycle across frame boundaries when the second bank is FULL (no idle cycle between dout_last and next sample).

Reset
REQ-024 SHALL, on rst, asynchronously set both banks EMPTY, both pointers 0, k = 0, bank contents 0.
REQ-025 SHALL, during and after reset, give dout_valid = 0, dout = 0, dout_index = 0, dout_last = 0, frame_ready = 1.
REQ-026 SHALL, on reset mid-frame, discard all buffered samples; no partial frame is emitted afterwards.

Configuration
REQ-027 SHALL, with macro FFT16_UNLOAD_NATURAL_ORDER_EN defined, emit for bin k the slot s = 4*(k mod 4) + (k div 4) (digit-reversal to natural order).
REQ-028 SHALL, without FFT16_UNLOAD_NATURAL_ORDER_EN, emit slot s = k (bus order); all handshake behaviour identical.

Verification
REQ-029 SHALL cover: macro on, slot s = s, one frame, dout_ready = 1 -> dout slots 0,4,8,12,1,5,9,13,2,6,10,14,3,7,11,15 on 16 consecutive cycles starting cycle after acceptance, dout_last on 16th only.
REQ-030 SHALL cover: macro off, same stimulus -> dout = slot 0..15 in order, dout_index = 0..15.
REQ-031 SHALL cover: three frames offered back-to-back, dout_ready = 1 -> frames 1,2 accepted on consecutive cycles, frame_ready = 0 until frame 1 drains, 48 samples with no gap.
REQ-032 SHALL cover: dout_ready toggling 1,0,1,0 -> each sample held stable across stall cycle, 16 samples in 32 cycles, order unchanged.
REQ-033 SHALL cover: rst asserted at dout_index = 7 with second bank FULL -> dout_valid = 0 immediately, frame_ready = 1, next accepted frame starts at index 0.
